// File: rtl/pll_drp_reconfig_pkg.sv
// Shared constants for the PLL DRP reconfiguration controller: FSM encodings,
// DRP register map (address / keep mask) and legal divide ranges.
package pll_drp_reconfig_pkg;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_CHECK     = 4'd1;
   localparam logic [3:0] S_RST_ON    = 4'd2;
   localparam logic [3:0] S_RD        = 4'd3;
   localparam logic [3:0] S_RD_WAIT   = 4'd4;
   localparam logic [3:0] S_WR        = 4'd5;
   localparam logic [3:0] S_WR_WAIT   = 4'd6;
   localparam logic [3:0] S_RST_OFF   = 4'd7;
   localparam logic [3:0] S_LOCK_WAIT = 4'd8;
   localparam logic [3:0] S_FINISH    = 4'd9;

   localparam logic [2:0] LAST_IDX = 3'd4;

   localparam logic [6:0] MULT_MIN    = 7'd2;
   localparam logic [6:0] MULT_MAX    = 7'd64;
   localparam logic [6:0] DIVCLK_MIN  = 7'd1;
   localparam logic [6:0] DIVCLK_MAX  = 7'd56;
   localparam logic [7:0] CLKOUT0_MIN = 8'd1;
   localparam logic [7:0] CLKOUT0_MAX = 8'd128;

   typedef struct packed {
      logic [6:0] mult;
      logic [6:0] divclk;
      logic [7:0] clkout0_div;
   } cfg_t;

   // Write order: CLKOUT0 Reg1/Reg2, CLKFBOUT Reg1/Reg2, DIVCLK
   function automatic logic [6:0] reg_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    return 7'h08;
         3'd1:    return 7'h09;
         3'd2:    return 7'h14;
         3'd3:    return 7'h15;
         default: return 7'h16;
      endcase
   endfunction

   function automatic logic [15:0] reg_keep(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd2: return 16'h1000;
         3'd1, 3'd3: return 16'hFC00;
         default:    return 16'hC000;
      endcase
   endfunction

endpackage

// File: rtl/pll_drp_reconfig_if.sv
// DRP bus between the reconfiguration controller (master) and the PLL DRP port (slave).
interface pll_drp_reconfig_if;
   logic [6:0]  drp_daddr;
   logic        drp_den;
   logic        drp_dwe;
   logic [15:0] drp_di;
   logic [15:0] drp_do;
   logic        drp_drdy;

   modport master (output drp_daddr, drp_den, drp_dwe, drp_di, input drp_do, drp_drdy);
   modport slave  (input drp_daddr, drp_den, drp_dwe, drp_di, output drp_do, drp_drdy);
endinterface

// File: rtl/pll_drp_reconfig_div_encode.sv
// Divide value D -> PLLE2 counter register fields (Reg1, Reg2 and the DIVCLK form).
module pll_drp_reconfig_div_encode (
   input  logic [7:0]  d,
   output logic [15:0] reg1,
   output logic [15:0] reg2,
   output logic [15:0] divclk_reg
);
   logic [5:0] hi, lo;
   logic       edge_b, nocnt;

   // Both halves are taken mod 64, so a divide of 128 encodes as hi=lo=0
   assign hi     = d[6:1];
   assign lo     = d[5:0] - d[6:1];
   assign edge_b = d[0];
   assign nocnt  = (d == 8'd1);

   assign reg1       = {4'b0000, hi, lo};
   assign reg2       = {8'h00, edge_b, nocnt, 6'b000000};
   assign divclk_reg = {2'b00, edge_b, nocnt, hi, lo};
endmodule

// File: rtl/pll_drp_reconfig.sv
// Runtime retune of one PLLE2_ADV over DRP: range check, hold PLL in reset,
// read-modify-write five counter registers, release and wait for lock.
module pll_drp_reconfig
   import pll_drp_reconfig_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 65535,
   parameter int SYNC_STAGES  = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [6:0] cfg_mult,
   input  logic [6:0] cfg_divclk,
   input  logic [7:0] cfg_clkout0_div,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       pll_rst,
   input  logic       pll_locked,
   pll_drp_reconfig_if.master drp
);
   localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

   logic [3:0]             state, state_nxt;
   cfg_t                   cfg_q;
   logic [2:0]             idx;
   logic [TO_W-1:0]        to_cnt, to_inc;
   logic [SYNC_STAGES-1:0] lock_sync;
   logic                   locked_s, cfg_bad, timeout;
   logic [7:0]             enc_d;
   logic [15:0]            enc_reg1, enc_reg2, enc_divclk, new_field;

   assign locked_s = lock_sync[SYNC_STAGES-1];
   assign to_inc   = to_cnt + TO_W'(1);
   assign timeout  = (to_inc == TO_W'(LOCK_TIMEOUT));

   assign cfg_bad = (cfg_q.mult < MULT_MIN) || (cfg_q.mult > MULT_MAX) ||
                    (cfg_q.divclk < DIVCLK_MIN) || (cfg_q.divclk > DIVCLK_MAX) ||
                    (cfg_q.clkout0_div < CLKOUT0_MIN) || (cfg_q.clkout0_div > CLKOUT0_MAX);

   // One shared encoder, its input steered by the register index
   always_comb begin
      enc_d = {1'b0, cfg_q.divclk};
      new_field = enc_divclk;
      case (idx)
         3'd0: begin enc_d = cfg_q.clkout0_div;   new_field = enc_reg1; end
         3'd1: begin enc_d = cfg_q.clkout0_div;   new_field = enc_reg2; end
         3'd2: begin enc_d = {1'b0, cfg_q.mult};  new_field = enc_reg1; end
         3'd3: begin enc_d = {1'b0, cfg_q.mult};  new_field = enc_reg2; end
         default: ;
      endcase
   end

   pll_drp_reconfig_div_encode u_enc (
      .d          (enc_d),
      .reg1       (enc_reg1),
      .reg2       (enc_reg2),
      .divclk_reg (enc_divclk)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (cfg_valid && cfg_ready) state_nxt = S_CHECK;
         S_CHECK:     state_nxt = cfg_bad ? S_FINISH : S_RST_ON;
         S_RST_ON:    state_nxt = S_RD;
         S_RD:        state_nxt = S_RD_WAIT;
         S_RD_WAIT:   if (drp.drp_drdy) state_nxt = S_WR;
         S_WR:        state_nxt = S_WR_WAIT;
         S_WR_WAIT:   if (drp.drp_drdy) state_nxt = (idx == LAST_IDX) ? S_RST_OFF : S_RD;
         S_RST_OFF:   state_nxt = S_LOCK_WAIT;
         S_LOCK_WAIT: if (locked_s || timeout) state_nxt = S_FINISH;
         S_FINISH:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         cfg_q         <= '0;
         idx           <= '0;
         to_cnt        <= '0;
         lock_sync     <= '0;
         cfg_ready     <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         pll_rst       <= 1'b0;
         drp.drp_den   <= 1'b0;
         drp.drp_dwe   <= 1'b0;
         drp.drp_daddr <= '0;
         drp.drp_di    <= '0;
      end else begin
         state       <= state_nxt;
         lock_sync   <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
         cfg_ready   <= (state_nxt == S_IDLE);
         busy        <= (state_nxt != S_IDLE);
         done        <= (state_nxt == S_FINISH);
         pll_rst     <= state_nxt inside {S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT};
         drp.drp_den <= (state_nxt == S_RD) || (state_nxt == S_WR);
         drp.drp_dwe <= (state_nxt == S_WR);
         case (state)
            S_IDLE:
               if (cfg_valid && cfg_ready) begin
                  cfg_q <= '{mult: cfg_mult, divclk: cfg_divclk, clkout0_div: cfg_clkout0_div};
                  error <= 1'b0;
               end
            S_CHECK:
               if (cfg_bad) error <= 1'b1;
            S_RST_ON: begin
               idx           <= '0;
               drp.drp_daddr <= reg_addr(3'd0);
            end
            S_RD_WAIT:
               if (drp.drp_drdy) drp.drp_di <= (drp.drp_do & reg_keep(idx)) | new_field;
            S_WR_WAIT:
               if (drp.drp_drdy && idx != LAST_IDX) begin
                  idx           <= idx + 3'd1;
                  drp.drp_daddr <= reg_addr(idx + 3'd1);
               end
            S_RST_OFF:
               to_cnt <= '0;
            S_LOCK_WAIT: begin
               to_cnt <= to_inc;
               if (!locked_s && timeout) error <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Bench for pll_drp_reconfig: DRP register-file / PLL lock model plus a
// field-level reference for the expected read-modify-write data.
module tb_pll_drp_reconfig;
   localparam int TO = 100;

   typedef struct {
      int addr;
      int data;
      bit rst_hi;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid, cfg_ready, busy, done, error, pll_rst, pll_locked;
   logic [6:0] cfg_mult, cfg_divclk;
   logic [7:0] cfg_clkout0_div;

   pll_drp_reconfig_if drp ();

   pll_drp_reconfig #(.LOCK_TIMEOUT(TO), .SYNC_STAGES(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_mult        (cfg_mult),
      .cfg_divclk      (cfg_divclk),
      .cfg_clkout0_div (cfg_clkout0_div),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .pll_rst         (pll_rst),
      .pll_locked      (pll_locked),
      .drp             (drp)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] regfile [128];
   wr_t         wq[$];
   int          den_cnt, viol, pend, p_addr, p_di, lk_cnt;
   int          lk_delay = 5;
   bit          p_we, rst_seen, never_lock, spurious, m_prev_rst;
   int          ADDR[5] = '{'h08, 'h09, 'h14, 'h15, 'h16};
   int          KEEP[5] = '{'h1000, 'hFC00, 'h1000, 'hFC00, 'hC000};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Field values from the divide arithmetic: kind 0 = Reg1, 1 = Reg2, 2 = DIVCLK
   function automatic int enc(input int d, input int kind);
      int hi, lo, e, nc;
      hi = (d / 2) % 64;
      lo = (d - d / 2) % 64;
      e  = d % 2;
      nc = (d == 1) ? 1 : 0;
      case (kind)
         0:       return hi * 64 + lo;
         1:       return e * 128 + nc * 64;
         default: return e * 8192 + nc * 4096 + hi * 64 + lo;
      endcase
   endfunction

   // DRP slave with 1-4 cycle drdy, and a PLL whose LOCKED drops in reset
   initial begin
      drp.drp_drdy = 1'b0;
      drp.drp_do   = '0;
      pll_locked   = 1'b0;
      pend = 0; lk_cnt = 0; m_prev_rst = 1'b0;
      forever begin
         @(posedge clk); #1;
         drp.drp_drdy = 1'b0;
         if (rst) pend = 0;
         else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  drp.drp_drdy = 1'b1;
                  if (p_we) regfile[p_addr] = 16'(p_di);
                  else drp.drp_do = regfile[p_addr];
               end
            end else if (spurious && pll_rst && !m_prev_rst) drp.drp_drdy = 1'b1;
            if (drp.drp_dwe && !drp.drp_den) viol++;
            if (drp.drp_den) begin
               if (pend != 0) viol++;
               den_cnt++;
               p_addr = int'(drp.drp_daddr);
               p_we   = drp.drp_dwe;
               p_di   = int'(drp.drp_di);
               pend   = $urandom_range(1, 4);
               if (drp.drp_dwe) wq.push_back('{int'(drp.drp_daddr), int'(drp.drp_di), pll_rst});
            end
         end
         if (pll_rst) rst_seen = 1'b1;
         if (m_prev_rst && !pll_rst) lk_delay = $urandom_range(3, 20);
         if (pll_rst) begin
            pll_locked = 1'b0;
            lk_cnt = 0;
         end else if (!pll_locked && !never_lock) begin
            lk_cnt++;
            if (lk_cnt >= lk_delay) pll_locked = 1'b1;
         end
         m_prev_rst = pll_rst;
      end
   end

   task automatic run_req(input int m, input int dv, input int c, input bit hold,
                          input int hm, input int hdv, input int hc, input string tag);
      int  exp_v[5];
      bit  legal, exp_err, prev_rst, rdy_bad;
      int  cyc, rst_fall;
      legal   = (m >= 2 && m <= 64) && (dv >= 1 && dv <= 56) && (c >= 1 && c <= 128);
      exp_err = !legal || never_lock;
      @(negedge clk);
      check({tag, " ready_idle"}, cfg_ready, 1);
      for (int k = 0; k < 5; k++) begin
         int d;
         d = (k < 2) ? c : (k < 4) ? m : dv;
         exp_v[k] = (int'(regfile[ADDR[k]]) & KEEP[k]) | enc(d, (k == 4) ? 2 : k % 2);
      end
      wq.delete(); den_cnt = 0; viol = 0; rst_seen = 1'b0;
      cfg_valid = 1'b1; cfg_mult = 7'(m); cfg_divclk = 7'(dv); cfg_clkout0_div = 8'(c);
      @(posedge clk); #1;
      if (hold) begin
         cfg_mult = 7'(hm); cfg_divclk = 7'(hdv); cfg_clkout0_div = 8'(hc);
      end else cfg_valid = 1'b0;
      check({tag, " busy_on_accept"}, busy, 1);
      cyc = 0; rst_fall = -1; rdy_bad = 1'b0; prev_rst = pll_rst;
      while (!done && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         if (prev_rst && !pll_rst) rst_fall = cyc;
         prev_rst = pll_rst;
         if (cfg_ready) rdy_bad = 1'b1;
      end
      check({tag, " done_seen"}, done, 1);
      check({tag, " error"}, error, exp_err);
      check({tag, " ready_low_while_busy"}, rdy_bad, 0);
      check({tag, " drp_protocol"}, viol, 0);
      if (!legal) begin
         check({tag, " reject_latency_le2"}, (cyc <= 2), 1);
         check({tag, " reject_no_den"}, den_cnt, 0);
         check({tag, " reject_no_pll_rst"}, rst_seen, 0);
      end else begin
         check({tag, " write_count"}, wq.size(), 5);
         for (int k = 0; k < 5; k++)
            if (k < wq.size()) begin
               check($sformatf("%s wr%0d_addr", tag, k), wq[k].addr, ADDR[k]);
               check($sformatf("%s wr%0d_data", tag, k), wq[k].data, exp_v[k]);
               check($sformatf("%s wr%0d_pll_rst", tag, k), wq[k].rst_hi, 1);
            end
         // pll_rst fall marks RST_OFF; LOCK_TIMEOUT wait cycles follow it
         if (never_lock) check({tag, " timeout_cycles"}, cyc - rst_fall, TO + 1);
      end
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " busy_cleared"}, busy, 0);
      check({tag, " ready_back"}, cfg_ready, 1);
   endtask

   initial begin
      int rdcnt, cyc;
      bit done_seen;
      rst = 1'b1; cfg_valid = 1'b0; cfg_mult = '0; cfg_divclk = '0; cfg_clkout0_div = '0;
      never_lock = 1'b0; spurious = 1'b0;
      for (int a = 0; a < 128; a++) regfile[a] = 16'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("rst cfg_ready", cfg_ready, 1);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst error", error, 0);
      check("rst pll_rst", pll_rst, 0);
      check("rst den", drp.drp_den, 0);
      check("rst dwe", drp.drp_dwe, 0);
      check("rst daddr", drp.drp_daddr, 0);
      check("rst di", drp.drp_di, 0);
      @(negedge clk); rst = 1'b0;
      repeat (25) @(posedge clk);

      run_req(36, 5, 6, 0, 0, 0, 0, "base");
      foreach (ADDR[k]) regfile[ADDR[k]] = 16'hFFFF;
      run_req(10, 1, 1, 0, 0, 0, 0, "clkout1");
      foreach (ADDR[k]) regfile[ADDR[k]] = 16'hFFFF;
      run_req(64, 56, 128, 0, 0, 0, 0, "clkout128");
      run_req(20, 0, 6, 0, 0, 0, 0, "divclk0");
      run_req(65, 4, 6, 0, 0, 0, 0, "mult65");
      run_req(2, 1, 0, 0, 0, 0, 0, "clkout0");

      never_lock = 1'b1;
      run_req(12, 2, 8, 0, 0, 0, 0, "timeout");
      never_lock = 1'b0;
      run_req(12, 2, 8, 0, 0, 0, 0, "recover");

      // Abort with reset while waiting on the third read
      @(negedge clk);
      cfg_valid = 1'b1; cfg_mult = 7'd24; cfg_divclk = 7'd3; cfg_clkout0_div = 8'd7;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      rdcnt = 0; cyc = 0;
      while (rdcnt < 3 && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
         if (drp.drp_den && !drp.drp_dwe) rdcnt++;
      end
      check("abort reached_rd3", rdcnt, 3);
      @(posedge clk); #1;
      rst = 1'b1; #1;
      check("abort cfg_ready", cfg_ready, 1);
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort pll_rst", pll_rst, 0);
      check("abort den", drp.drp_den, 0);
      check("abort daddr", drp.drp_daddr, 0);
      check("abort di", drp.drp_di, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      done_seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) done_seen = 1'b1;
      end
      check("abort no_done", done_seen, 0);
      repeat (25) @(posedge clk);
      run_req(40, 4, 9, 0, 0, 0, 0, "after_abort");

      spurious = 1'b1;
      run_req(20, 2, 10, 1, 30, 3, 12, "hold_first");
      spurious = 1'b0;
      run_req(30, 3, 12, 0, 0, 0, 0, "hold_second");

      for (int i = 0; i < 8; i++)
         run_req($urandom_range(1, 66), $urandom_range(0, 58), $urandom_range(0, 130),
                 0, 0, 0, 0, $sformatf("rand%0d", i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
